// File: rtl/spi_slave_interface.sv
// SPI responder for mode CPOL=1 / CPHA=1 (SCL idles high, drive on fall,
// sample on rise). The SPI pins are oversampled in the clk domain; the user
// side exchanges whole bytes through tx_load / rx_valid pulses.
module spi_slave_interface #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic [7:0] byte_2_send,
    output logic [7:0] byte_received,
    output logic       rx_valid,
    output logic       tx_load,
    input  logic       msb_lsb,
    output logic       busy,
    input  logic       scl,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Synchronizer chains and one-flop delayed copies for edge detection
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   scl_dly_q;
    logic                   cs_dly_q;

    logic scl_s;
    logic cs_s;
    logic mosi_s;
    logic scl_fall;
    logic scl_rise;
    logic cs_fall;
    logic cs_rise;

    // Protocol state
    state_e     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] byte_received_q, byte_received_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       miso_q, miso_d;

    logic [7:0] rx_next;
    logic [2:0] rx_idx;
    logic [2:0] tx_idx;

    // Bring scl, cs and mosi into the clk domain through equal-depth chains.
    // The scl and cs chains reset to their idle level so that leaving reset
    // with an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_sync_q  <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            scl_dly_q   <= 1'b1;
            cs_dly_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop of the chain sample
            // the previous value of its neighbour, which is what makes it a chain.
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            scl_dly_q   <= scl_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign scl_fall = scl_dly_q & ~scl_s;
    assign scl_rise = ~scl_dly_q & scl_s;
    assign cs_fall  = cs_dly_q & ~cs_s;
    assign cs_rise  = ~cs_dly_q & cs_s;

    // Bit positions follow msb_lsb on every bit
    assign rx_idx = msb_lsb ? (3'd7 - rx_cnt_q) : rx_cnt_q;
    assign tx_idx = msb_lsb ? (3'd7 - tx_cnt_q[2:0]) : tx_cnt_q[2:0];

    // Register all protocol state
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q         <= IDLE;
            tx_shift_q      <= '0;
            rx_shift_q      <= '0;
            tx_cnt_q        <= '0;
            rx_cnt_q        <= '0;
            byte_received_q <= '0;
            rx_valid_q      <= 1'b0;
            tx_load_q       <= 1'b0;
            miso_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            tx_shift_q      <= tx_shift_d;
            rx_shift_q      <= rx_shift_d;
            tx_cnt_q        <= tx_cnt_d;
            rx_cnt_q        <= rx_cnt_d;
            byte_received_q <= byte_received_d;
            rx_valid_q      <= rx_valid_d;
            tx_load_q       <= tx_load_d;
            miso_q          <= miso_d;
        end
    end

    // Next-state and output decode; a cs edge always takes priority over scl
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        tx_shift_d      = tx_shift_q;
        rx_shift_d      = rx_shift_q;
        tx_cnt_d        = tx_cnt_q;
        rx_cnt_d        = rx_cnt_q;
        byte_received_d = byte_received_q;
        rx_valid_d      = 1'b0;
        tx_load_d       = 1'b0;
        miso_d          = miso_q;
        rx_next         = rx_shift_q;
        rx_next[rx_idx] = mosi_s;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d    = SHIFT;
                    tx_shift_d = byte_2_send;
                    tx_load_d  = 1'b1;
                    tx_cnt_d   = '0;
                    rx_cnt_d   = '0;
                    rx_shift_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    // Abort: any partial byte is dropped silently
                    state_d  = IDLE;
                    miso_d   = 1'b0;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                end else if (scl_fall) begin
                    if (tx_cnt_q < 4'd8) begin
                        miso_d   = tx_shift_q[tx_idx];
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end else if (scl_rise) begin
                    rx_shift_d = rx_next;
                    if (rx_cnt_q == 3'd7) begin
                        // Byte complete: hand it over and reload for the next one
                        byte_received_d = rx_next;
                        rx_valid_d      = 1'b1;
                        tx_shift_d      = byte_2_send;
                        tx_load_d       = 1'b1;
                        rx_cnt_d        = '0;
                        tx_cnt_d        = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_received = byte_received_q;
    assign rx_valid      = rx_valid_q;
    assign tx_load       = tx_load_q;
    assign miso          = miso_q;
    assign busy          = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave_interface.sv
// Self-checking bench for spi_slave_interface: a mode 1,1 bus-functional
// master with a scoreboard of expected received bytes.
module tb_spi_slave_interface;

    logic       clk;
    logic       arstn;
    logic [7:0] byte_2_send;
    logic [7:0] byte_received;
    logic       rx_valid;
    logic       tx_load;
    logic       msb_lsb;
    logic       busy;
    logic       scl;
    logic       cs;
    logic       mosi;
    logic       miso;

    int         n_checks;
    int         n_errors;
    int         rxv_cnt;
    int         txl_cnt;
    logic       tb_msb;
    logic [7:0] exp_q[$];

    localparam int HALF = 50;

    spi_slave_interface #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .byte_2_send  (byte_2_send),
        .byte_received(byte_received),
        .rx_valid     (rx_valid),
        .tx_load      (tx_load),
        .msb_lsb      (msb_lsb),
        .busy         (busy),
        .scl          (scl),
        .cs           (cs),
        .mosi         (mosi),
        .miso         (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clk step, observed on the falling clk edge; pops the scoreboard on rx_valid
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (tx_load === 1'b1) txl_cnt++;
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rx_unexpected: rx_valid with byte_received=%h, no byte expected", byte_received);
            end else begin
                e = exp_q.pop_front();
                if (byte_received !== e) begin
                    n_errors++;
                    $display("FAIL rx_byte: got %h, expected %h", byte_received, e);
                end
            end
            n_checks++;
            if (tx_load !== 1'b1) begin
                n_errors++;
                $display("FAIL tx_load_with_rx_valid: got %b, expected 1", tx_load);
            end
        end
    endtask

    task automatic wait_clk(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Master clocks out nbits of tx and collects what it samples on miso
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            idx  = tb_msb ? 7 - i : i;
            scl  = 1'b0;
            mosi = tx[idx];
            wait_clk(HALF);
            scl     = 1'b1;
            rx[idx] = miso;
            wait_clk(HALF);
        end
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        wait_clk(10);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        wait_clk(20);
    endtask

    task automatic check_counts(input string name, input int rxv, input int txl,
                                input int rxv_base, input int txl_base);
        n_checks++;
        if (rxv_cnt - rxv_base !== rxv) begin
            n_errors++;
            $display("FAIL %s_rx_valid_count: got %0d, expected %0d", name, rxv_cnt - rxv_base, rxv);
        end
        n_checks++;
        if (txl_cnt - txl_base !== txl) begin
            n_errors++;
            $display("FAIL %s_tx_load_count: got %0d, expected %0d", name, txl_cnt - txl_base, txl);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_missing_rx: %0d bytes still expected", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        wait_clk(3);
        n_checks++;
        if ({byte_received, rx_valid, tx_load, busy, miso} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_outputs: got br=%h rv=%b tl=%b busy=%b miso=%b, expected all 0",
                     byte_received, rx_valid, tx_load, busy, miso);
        end
        arstn = 1'b1;
        wait_clk(5);
        n_checks++;
        if ({rx_valid, tx_load, busy, miso} !== 4'h0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got rv=%b tl=%b busy=%b miso=%b, expected 0",
                     rx_valid, tx_load, busy, miso);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] r;
        int rb, tb;
        rb = rxv_cnt; tb = txl_cnt;
        tb_msb = 1'b1; msb_lsb = 1'b1; byte_2_send = 8'h3C;
        exp_q.push_back(8'hA5);
        cs_begin();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_during_cs: got %b, expected 1", busy);
        end
        spi_bits(8'hA5, 8, r);
        cs_end();
        n_checks++;
        if (r !== 8'h3C) begin
            n_errors++;
            $display("FAIL msb_master_read: got %h, expected 3c", r);
        end
        n_checks++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            n_errors++;
            $display("FAIL msb_idle_after: got busy=%b miso=%b, expected 0 0", busy, miso);
        end
        check_counts("msb", 1, 2, rb, tb);
    endtask

    task automatic test_lsb_first();
        logic [7:0] r;
        int rb, tb;
        rb = rxv_cnt; tb = txl_cnt;
        tb_msb = 1'b0; msb_lsb = 1'b0; byte_2_send = 8'h80;
        exp_q.push_back(8'h01);
        cs_begin();
        spi_bits(8'h01, 8, r);
        cs_end();
        n_checks++;
        if (r[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL lsb_first_miso_bit: got %b, expected 0", r[0]);
        end
        n_checks++;
        if (r !== 8'h80) begin
            n_errors++;
            $display("FAIL lsb_master_read: got %h, expected 80", r);
        end
        check_counts("lsb", 1, 2, rb, tb);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r0, r1;
        int rb, tb;
        rb = rxv_cnt; tb = txl_cnt;
        tb_msb = 1'b1; msb_lsb = 1'b1; byte_2_send = 8'h56;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        cs_begin();
        byte_2_send = 8'h9A;
        spi_bits(8'h12, 8, r0);
        spi_bits(8'h34, 8, r1);
        cs_end();
        n_checks++;
        if (r0 !== 8'h56) begin
            n_errors++;
            $display("FAIL b2b_read0: got %h, expected 56", r0);
        end
        n_checks++;
        if (r1 !== 8'h9A) begin
            n_errors++;
            $display("FAIL b2b_read1: got %h, expected 9a", r1);
        end
        check_counts("b2b", 2, 3, rb, tb);
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int rb, tb;
        rb = rxv_cnt; tb = txl_cnt;
        tb_msb = 1'b1; msb_lsb = 1'b1; byte_2_send = 8'hFF;
        cs_begin();
        spi_bits(8'hF0, 4, r);
        cs_end();
        n_checks++;
        if (byte_received !== 8'h34) begin
            n_errors++;
            $display("FAIL abort_hold: got %h, expected 34", byte_received);
        end
        n_checks++;
        if (miso !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle: got miso=%b busy=%b, expected 0 0", miso, busy);
        end
        check_counts("abort", 0, 1, rb, tb);
        rb = rxv_cnt; tb = txl_cnt;
        byte_2_send = 8'h5A;
        exp_q.push_back(8'hC3);
        cs_begin();
        spi_bits(8'hC3, 8, r);
        cs_end();
        n_checks++;
        if (r !== 8'h5A) begin
            n_errors++;
            $display("FAIL abort_next_read: got %h, expected 5a", r);
        end
        check_counts("after_abort", 1, 2, rb, tb);
    endtask

    task automatic test_cs_high();
        int rb, tb;
        rb = rxv_cnt; tb = txl_cnt;
        for (int i = 0; i < 16; i++) begin
            scl  = ~scl;
            mosi = i[0];
            wait_clk(10);
            n_checks++;
            if (miso !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL cs_high_toggle%0d: got miso=%b busy=%b, expected 0 0", i, miso, busy);
            end
        end
        check_counts("cs_high", 0, 0, rb, tb);
    endtask

    task automatic test_mid_reset();
        logic [7:0] r;
        int rb, tb;
        tb_msb = 1'b1; msb_lsb = 1'b1; byte_2_send = 8'hE7;
        cs_begin();
        spi_bits(8'hAA, 3, r);
        arstn = 1'b0;
        #1;
        n_checks++;
        if ({byte_received, rx_valid, tx_load, busy, miso} !== 12'h000) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got br=%h rv=%b tl=%b busy=%b miso=%b, expected all 0",
                     byte_received, rx_valid, tx_load, busy, miso);
        end
        cs  = 1'b1;
        scl = 1'b1;
        wait_clk(5);
        arstn = 1'b1;
        wait_clk(5);
        rb = rxv_cnt; tb = txl_cnt;
        byte_2_send = 8'h81;
        exp_q.push_back(8'h7E);
        cs_begin();
        spi_bits(8'h7E, 8, r);
        cs_end();
        n_checks++;
        if (r !== 8'h81) begin
            n_errors++;
            $display("FAIL post_reset_read: got %h, expected 81", r);
        end
        check_counts("post_reset", 1, 2, rb, tb);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; rxv_cnt = 0; txl_cnt = 0;
        arstn = 1'b0; scl = 1'b1; cs = 1'b1; mosi = 1'b0;
        byte_2_send = 8'h00; msb_lsb = 1'b1; tb_msb = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_abort();
        test_cs_high();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
